lz77_token_unpacker: RTL and testbench
======================================

# lz77_token_unpacker

- Upstream feeder for `lz77_decomp_core`.
- Accepts the compressed stream as 8-bit AXI-Stream bytes and assembles each group of three bytes into one (distance, length, literal) token.
- Presents each token on a valid/ready interface that connects directly to the core's `in_valid`/`in_ready`/`in_distance`/`in_length`/`in_literal`.
- Optionally flags malformed input.

## Interface
Parameters:
- `DIST_WIDTH`, 4: distance field width, 1..8.
- `LEN_WIDTH`, 4: length field width, 1..8.

Ports:
- `clk`  in  1  sole clock; all logic on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `s_axis_tdata`  in  8  compressed byte.
- `s_axis_tvalid`  in  1  byte valid.
- `s_axis_tready`  out  1  byte accepted when high with tvalid.
- `s_axis_tlast`  in  1  last byte of the stream.
- `out_valid`  out  1  token available.
- `out_ready`  in  1  consumer accepts the token; tie to core `in_ready`.
- `out_distance`  out  DIST_WIDTH  match distance.
- `out_length`  out  LEN_WIDTH  match length.
- `out_literal`  out  8  trailing literal.
- `out_last`  out  1  token carried tlast on its literal byte.
- `err_status`  out  3  sticky error flags; bit0 truncated, bit1 field overflow, bit2 zero-distance match.

## Operation
- Byte order per token:
  - byte0 is distance; the low DIST_WIDTH bits are used.
  - byte1 is length; the low LEN_WIDTH bits are used.
  - byte2 is the literal.
- FSM states are `S_DIST` → `S_LEN` → `S_LIT` → `S_DIST`. Each transition occurs on an accepted byte (tvalid & tready).
- Staging registers capture distance and length in `S_DIST` and `S_LEN`.
- Output slot is a single register: token, out_valid, out_last.
  - On an accepted literal byte, the slot loads {staged distance, staged length, tdata, tlast} and out_valid is set.
  - out_valid clears on out_valid & out_ready unless the slot reloads in the same cycle.
- Backpressure rules:
  - In `S_DIST` and `S_LEN`, s_axis_tready = 1 (staging is independent of the slot).
  - In `S_LIT`, s_axis_tready = !out_valid | out_ready.
  - Simultaneous drain and reload is allowed, so no bubble is inserted.
- Outputs never change while out_valid & !out_ready.
- tlast on byte0 or byte1 has no structural effect without the error feature (see Configuration).
- Reset mid-token discards the partial staging and any slot contents.

## Timing
- Reset values:
  - state `S_DIST`.
  - `s_axis_tready` = 1.
  - `out_valid`, `out_last`, `out_distance`, `out_length`, `out_literal`, `err_status` all 0.
- Latency: literal byte accepted at edge N → out_valid = 1 from edge N.
- Throughput: 1 token per 3 accepted bytes. Sustained with out_ready held high.
- `s_axis_tready` in `S_LIT` depends combinationally on `out_ready`. There is no combinational path from tvalid to tready.
- err_status bits set on the edge the offending byte is accepted. They clear only on reset.

## Configuration
- Macro `LZ77_UNPACK_ERR_CHECK_EN`.
- Defined:
  - tlast accepted in `S_DIST`/`S_LEN` sets bit0, drops the partial token and returns to `S_DIST`.
  - Nonzero bits above DIST_WIDTH/LEN_WIDTH in byte0/byte1 set bit1. The token is still emitted, masked.
  - An emitted token with distance==0 and length!=0 sets bit2. The token is still emitted.
- Undefined:
  - `err_status` tied to 0.
  - tlast is ignored except on the literal byte.
  - Upper bits are silently masked.

## Structure
- Package `lz77_pkg` holds:
  - the token struct (distance, length, literal, last).
  - the FSM state enum.
  - the `ERR_TRUNC`/`ERR_FIELD`/`ERR_ZDIST` bit-index constants.
  - the default width constants shared with `lz77_decomp_core`.
- One sub-module, `lz77_token_slot`: the single-entry valid/ready holding register with load/drain arbitration.

## Test plan
- Bytes 00 00 31, 00 00 30, 02 02 41, out_ready = 1 → tokens (0,0,0x31), (0,0,0x30), (2,2,0x41). Each out_valid asserts the edge after its literal byte.
- Two tokens back-to-back with out_ready = 0 for 5 cycles after the first → tready low in `S_LIT`. First token held stable. Second emitted after release, nothing lost.
- 02 02 58 with tlast on 0x58 → token (2,2,0x58) with out_last = 1.
- With macro: bytes 03 then tlast on 02 → no token emitted, err_status = 3'b001, next bytes 00 00 42 → (0,0,0x42).
- With macro: bytes F3 01 41 → token (3,1,0x41), err_status[1] = 1. Then 00 05 41 → err_status[2] = 1.
- rst pulsed after byte0 and byte1 of a token → out_valid 0, state `S_DIST`. Next 00 00 31 decodes correctly.

Source files
------------

// File: rtl/lz77_pkg.sv
// Shared types and constants for the LZ77 token path (unpacker and decompression core).
package lz77_pkg;

  localparam int DIST_WIDTH_DEF = 4;
  localparam int LEN_WIDTH_DEF  = 4;

  // Bit positions inside err_status.
  localparam int ERR_TRUNC = 0;
  localparam int ERR_FIELD = 1;
  localparam int ERR_ZDIST = 2;

  typedef enum logic [1:0] {
    S_DIST = 2'd0,
    S_LEN  = 2'd1,
    S_LIT  = 2'd2
  } lz77_state_e;

  // Byte-wide fields so the struct fits any DIST_WIDTH/LEN_WIDTH up to 8.
  typedef struct packed {
    logic [7:0] distance;
    logic [7:0] length;
    logic [7:0] literal;
    logic       last;
  } lz77_token_t;

endpackage

// File: rtl/lz77_token_slot.sv
// Single-entry valid/ready holding register; a load and a drain may share one cycle.
module lz77_token_slot
  import lz77_pkg::*;
#(
  parameter int W = 18
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_data,
  input  logic         ready,
  output logic         valid,
  output logic [W-1:0] data,
  output logic         can_load
);

  // Handshake: an entry leaves when valid & ready at a rising edge; load is only
  // asserted by the owner while can_load is high, so a held entry is never overwritten.
  assign can_load = !valid || ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= load_data;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/lz77_token_unpacker.sv
// Packs 3-byte AXI-Stream groups (distance, length, literal) into LZ77 tokens.
// Optional malformed-input detection is built when LZ77_UNPACK_ERR_CHECK_EN is defined.
module lz77_token_unpacker
  import lz77_pkg::*;
#(
  parameter int DIST_WIDTH = DIST_WIDTH_DEF,
  parameter int LEN_WIDTH  = LEN_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DIST_WIDTH-1:0] out_distance,
  output logic [LEN_WIDTH-1:0]  out_length,
  output logic [7:0]            out_literal,
  output logic                  out_last,
  output logic [2:0]            err_status,
  output lz77_state_e           dbg_state
);

  localparam int TW = DIST_WIDTH + LEN_WIDTH + 9;

  lz77_state_e           state_q, state_d;
  logic [DIST_WIDTH-1:0] dist_q;
  logic [LEN_WIDTH-1:0]  len_q;
  logic                  byte_acc;
  logic                  slot_load;
  logic                  slot_can_load;
  logic                  abort;
  logic [TW-1:0]         slot_data;

`ifdef LZ77_UNPACK_ERR_CHECK_EN
  assign abort = s_axis_tlast;
`else
  assign abort = 1'b0;
`endif

  assign byte_acc  = s_axis_tvalid && s_axis_tready;
  assign dbg_state = state_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_DIST;
    else     state_q <= state_d;
  end

  // tready depends only on state and out_ready, never on tvalid.
  always_comb begin
    state_d       = state_q;
    s_axis_tready = 1'b1;
    slot_load     = 1'b0;
    case (state_q)
      S_DIST: if (byte_acc) state_d = abort ? S_DIST : S_LEN;
      S_LEN:  if (byte_acc) state_d = abort ? S_DIST : S_LIT;
      S_LIT: begin
        s_axis_tready = slot_can_load;
        if (byte_acc) begin
          slot_load = 1'b1;
          state_d   = S_DIST;
        end
      end
      default: state_d = S_DIST;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dist_q <= '0;
      len_q  <= '0;
    end else if (byte_acc) begin
      if (state_q == S_DIST) dist_q <= s_axis_tdata[DIST_WIDTH-1:0];
      if (state_q == S_LEN)  len_q  <= s_axis_tdata[LEN_WIDTH-1:0];
    end
  end

  lz77_token_slot #(.W(TW)) u_slot (
    .clk       (clk),
    .rst       (rst),
    .load      (slot_load),
    .load_data ({dist_q, len_q, s_axis_tdata, s_axis_tlast}),
    .ready     (out_ready),
    .valid     (out_valid),
    .data      (slot_data),
    .can_load  (slot_can_load)
  );

  assign {out_distance, out_length, out_literal, out_last} = slot_data;

`ifdef LZ77_UNPACK_ERR_CHECK_EN
  logic [2:0] err_q;

  // Shifting instead of slicing keeps the upper-bit test legal when a field is 8 bits wide.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= '0;
    end else if (byte_acc) begin
      case (state_q)
        S_DIST: begin
          if (s_axis_tlast) err_q[ERR_TRUNC] <= 1'b1;
          if ((s_axis_tdata >> DIST_WIDTH) != 8'd0) err_q[ERR_FIELD] <= 1'b1;
        end
        S_LEN: begin
          if (s_axis_tlast) err_q[ERR_TRUNC] <= 1'b1;
          if ((s_axis_tdata >> LEN_WIDTH) != 8'd0) err_q[ERR_FIELD] <= 1'b1;
        end
        S_LIT: if (dist_q == '0 && len_q != '0) err_q[ERR_ZDIST] <= 1'b1;
        default: ;
      endcase
    end
  end

  assign err_status = err_q;
`else
  assign err_status = 3'b000;
`endif

endmodule

// File: tb/tb_lz77_token_unpacker.sv
// Randomized scoreboard bench for lz77_token_unpacker against a byte-group reference model.
module tb_lz77_token_unpacker;
  import lz77_pkg::*;

  localparam int DW = 4;
  localparam int LW = 4;
  localparam logic [7:0] MASK_D = 8'((1 << DW) - 1);
  localparam logic [7:0] MASK_L = 8'((1 << LW) - 1);
`ifdef LZ77_UNPACK_ERR_CHECK_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [7:0]    s_axis_tdata = 8'd0;
  logic          s_axis_tvalid = 1'b0;
  logic          s_axis_tready;
  logic          s_axis_tlast = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [DW-1:0] out_distance;
  logic [LW-1:0] out_length;
  logic [7:0]    out_literal;
  logic          out_last;
  logic [2:0]    err_status;
  lz77_state_e   dbg_state;

  lz77_token_unpacker #(.DIST_WIDTH(DW), .LEN_WIDTH(LW)) dut (
    .clk           (clk),
    .rst           (rst),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tlast  (s_axis_tlast),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_distance  (out_distance),
    .out_length    (out_length),
    .out_literal   (out_literal),
    .out_last      (out_last),
    .err_status    (err_status),
    .dbg_state     (dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_fail = 0;
  logic [24:0] exp_q[$];
  logic [7:0]  grp[$];
  logic [2:0]  err_exp = 3'b000;
  int          rdy_mode = 0;  // 0: ready high, 1: random, 2: held low

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    case (rdy_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = ($urandom_range(0, 3) != 0);
      default: out_ready = 1'b0;
    endcase
  end

  // Reference model: collect bytes into groups of three; returns 1 when a token is emitted.
  function automatic bit model_accept(input logic [7:0] b, input logic last);
    lz77_token_t t;
    int pos;
    pos = grp.size();
    if (ERR_EN && pos == 0 && (b & ~MASK_D) != 8'd0) err_exp[ERR_FIELD] = 1'b1;
    if (ERR_EN && pos == 1 && (b & ~MASK_L) != 8'd0) err_exp[ERR_FIELD] = 1'b1;
    if (pos < 2) begin
      if (ERR_EN && last) begin
        err_exp[ERR_TRUNC] = 1'b1;
        grp.delete();
      end else begin
        grp.push_back(b);
      end
      return 1'b0;
    end
    t.distance = grp[0] & MASK_D;
    t.length   = grp[1] & MASK_L;
    t.literal  = b;
    t.last     = last;
    if (ERR_EN && t.distance == 8'd0 && t.length != 8'd0) err_exp[ERR_ZDIST] = 1'b1;
    grp.delete();
    exp_q.push_back(t);
    return 1'b1;
  endfunction

  // Driver
  task automatic send_byte(input logic [7:0] b, input logic last);
    bit acc;
    bit lit;
    int guard;
    acc = 1'b0;
    guard = 0;
    @(negedge clk);
    s_axis_tdata  = b;
    s_axis_tlast  = last;
    s_axis_tvalid = 1'b1;
    while (!acc) begin
      #1;
      acc = s_axis_tready;
      @(posedge clk);
      if (!acc) begin
        guard++;
        if (guard > 200) begin
          n_cmp++;
          n_fail++;
          $display("FAIL accept_timeout: byte %0h never accepted", b);
          break;
        end
        @(negedge clk);
      end
    end
    if (acc) begin
      lit = model_accept(b, last);
      #1;
      check("err_status", {29'd0, err_status}, {29'd0, err_exp});
      if (lit) check("latency_valid", {31'd0, out_valid}, 32'd1);
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic send_tok(input logic [7:0] d, input logic [7:0] l, input logic [7:0] c,
                          input logic last);
    send_byte(d, 1'b0);
    send_byte(l, 1'b0);
    send_byte(c, last);
  endtask

  task automatic wait_drain();
    int guard;
    guard = 0;
    while (exp_q.size() != 0 && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    check("drain_empty", exp_q.size(), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    #2;
    exp_q.delete();
    grp.delete();
    err_exp = 3'b000;
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_state", {30'd0, dbg_state}, {30'd0, S_DIST});
    check("rst_tready", {31'd0, s_axis_tready}, 32'd1);
    check("rst_outs", {out_distance, out_length, out_literal, out_last, err_status},
          {DW'(0), LW'(0), 8'd0, 1'b0, 3'b000});
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Scoreboard monitor: samples mid-cycle, after out_ready has settled.
  initial begin
    lz77_token_t cur;
    logic [25:0] held;
    bit held_v;
    held_v = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        held_v = 1'b0;
      end else begin
        cur.distance = 8'(out_distance);
        cur.length   = 8'(out_length);
        cur.literal  = out_literal;
        cur.last     = out_last;
        if (held_v) check("stall_hold", {6'd0, out_valid, cur}, {6'd0, held});
        held_v = out_valid && !out_ready;
        held = {out_valid, cur};
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_token: got %0h expected none", cur);
          end else begin
            check("token", {7'd0, cur}, {7'd0, exp_q.pop_front()});
          end
        end
      end
    end
  end

  initial begin
    do_reset();

    // Basic decode with ready held high.
    rdy_mode = 0;
    send_tok(8'h00, 8'h00, 8'h31, 1'b0);
    send_tok(8'h00, 8'h00, 8'h30, 1'b0);
    send_tok(8'h02, 8'h02, 8'h41, 1'b0);
    wait_drain();

    // Backpressure: first token held while out_ready is low for five cycles.
    rdy_mode = 2;
    @(negedge clk);
    send_tok(8'h01, 8'h03, 8'h55, 1'b0);
    send_byte(8'h04, 1'b0);
    send_byte(8'h02, 1'b0);
    repeat (5) begin
      @(negedge clk);
      #1;
      check("tready_stall", {31'd0, s_axis_tready}, 32'd0);
    end
    rdy_mode = 0;
    send_byte(8'h66, 1'b0);
    wait_drain();

    // tlast on the literal byte.
    send_tok(8'h02, 8'h02, 8'h58, 1'b1);
    wait_drain();

`ifdef LZ77_UNPACK_ERR_CHECK_EN
    send_byte(8'h03, 1'b0);
    send_byte(8'h02, 1'b1);
    send_tok(8'h00, 8'h00, 8'h42, 1'b0);
    wait_drain();
    check("err_trunc", {29'd0, err_status}, 32'd1);
    send_tok(8'hF3, 8'h01, 8'h41, 1'b0);
    send_tok(8'h00, 8'h05, 8'h41, 1'b0);
    wait_drain();
    check("err_all", {29'd0, err_status}, 32'd7);
    do_reset();
`endif

    // Reset in the middle of a token.
    send_byte(8'h05, 1'b0);
    send_byte(8'h06, 1'b0);
    do_reset();
    send_tok(8'h00, 8'h00, 8'h31, 1'b0);
    wait_drain();

    // Randomized traffic with random gaps, random tlast and random out_ready.
    rdy_mode = 1;
    for (int i = 0; i < 120; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      send_byte(8'($urandom_range(0, 255)), ($urandom_range(0, 9) == 0));
    end
    rdy_mode = 0;
    wait_drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
